// File: rtl/riscv_trap_controller_pkg.sv
// riscv_trap_controller_pkg: shared types, cause codes and context layout for the trap controller.
// Rev 1.0
`default_nettype none

package riscv_trap_controller_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENTER    = 2'd1,
    RETURN   = 2'd2,
    REDIRECT = 2'd3
  } trap_state_t;

  // Interrupt cause codes
  localparam logic [4:0] CAUSE_SW_INT    = 5'd3;
  localparam logic [4:0] CAUSE_TIMER_INT = 5'd7;

  // Exception cause codes
  localparam logic [4:0] CAUSE_MISALIGNED_FETCH = 5'd0;
  localparam logic [4:0] CAUSE_FETCH_FAULT      = 5'd1;
  localparam logic [4:0] CAUSE_ILLEGAL_INSN     = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT       = 5'd3;
  localparam logic [4:0] CAUSE_MISALIGNED_LOAD  = 5'd4;
  localparam logic [4:0] CAUSE_LOAD_FAULT       = 5'd5;
  localparam logic [4:0] CAUSE_MISALIGNED_STORE = 5'd6;
  localparam logic [4:0] CAUSE_STORE_FAULT      = 5'd7;
  localparam logic [4:0] CAUSE_ECALL_M          = 5'd11;

  localparam int MIE_MSIE    = 3;
  localparam int MIE_MTIE    = 7;
  localparam int MIE_IRQ_LSB = 16;

  localparam int CTX_IE           = 0;
  localparam int CTX_IE1          = 1;
  localparam int CTX_MCAUSE_LSB   = 2;
  localparam int CTX_MBADADDR_LSB = 8;

  localparam int         MCAUSE_INT_BIT       = 5;
  localparam logic [1:0] MTVEC_MODE_VECTORED  = 2'd1;

  function automatic logic [31:0] trap_vector(input logic [31:0] mtvec,
                                              input logic [5:0]  cause,
                                              input logic [31:0] reset_vector);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (mtvec == 32'd0) return reset_vector;
    if (mtvec[1:0] == MTVEC_MODE_VECTORED && cause[MCAUSE_INT_BIT])
      return base + {25'd0, cause[4:0], 2'b00};
    return base;
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_irq_priority_encoder.sv
// riscv_irq_priority_encoder: selects the highest-priority enabled interrupt source.
// Rev 1.0
`default_nettype none

module riscv_irq_priority_encoder
  import riscv_trap_controller_pkg::*;
#(
  parameter int EXT_IRQ_CODE_BASE = 16
) (
  input  logic        sw,
  input  logic        timer,
  input  logic [7:0]  irq,
  input  logic [31:0] mie,
  input  logic        ie,
  output logic        pending,
  output logic [4:0]  code
);

  localparam logic [4:0] IRQ_BASE = 5'(EXT_IRQ_CODE_BASE);

  logic [7:0] irq_en;
  logic       unused_mie;

  assign irq_en     = irq & mie[MIE_IRQ_LSB +: 8];
  assign unused_mie = ^{mie[31:24], mie[15:8], mie[6:4], mie[2:0]};

  // Scan irq from high to low so the lowest index is the one left in code.
  always_comb begin
    pending = 1'b0;
    code    = 5'd0;
    if (ie) begin
      if (sw && mie[MIE_MSIE]) begin
        pending = 1'b1;
        code    = CAUSE_SW_INT;
      end else if (timer && mie[MIE_MTIE]) begin
        pending = 1'b1;
        code    = CAUSE_TIMER_INT;
      end else begin
        for (int n = 7; n >= 0; n--) begin
          if (irq_en[n]) begin
            pending = 1'b1;
            code    = IRQ_BASE + 5'(n);
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/riscv_trap_controller.sv
// riscv_trap_controller: trap/MRET arbitration, CSR context writes and fetch redirect.
// Rev 1.0
`default_nettype none

module riscv_trap_controller
  import riscv_trap_controller_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR      = 32'h0000_0000,
  parameter int          EXT_IRQ_CODE_BASE = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_badaddr,
  input  logic        commit_valid,
  input  logic [31:0] commit_next_pc,
  input  logic        mret_valid,
  input  logic        software_interrupt_in,
  input  logic        timer_interrupt_in,
  input  logic [7:0]  irq,
  input  logic [31:0] mie_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  input  logic        ie_in,
  input  logic        ie1_in,
  output logic [39:0] exception_context,
  output logic        exception_context_write,
  output logic [31:0] mepc_out,
  output logic        mepc_write,
  output logic        stall_out,
  output logic        flush_out,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  trap_state_t state, state_next;

  logic        int_pending;
  logic [4:0]  int_code;
  logic        take_int;
  logic [5:0]  cause;
  logic [31:0] badaddr;
  logic [31:0] epc;
  logic        ie_snap;
  logic [31:0] target;
  logic [5:0]  last_cause;
  logic [31:0] last_badaddr;

  riscv_irq_priority_encoder #(
    .EXT_IRQ_CODE_BASE (EXT_IRQ_CODE_BASE)
  ) u_prio (
    .sw      (software_interrupt_in),
    .timer   (timer_interrupt_in),
    .irq     (irq),
    .mie     (mie_in),
    .ie      (ie_in),
    .pending (int_pending),
    .code    (int_code)
  );

  // An MRET outranks interrupts, so it also blocks them at the boundary.
  assign take_int = commit_valid && !exc_valid && !mret_valid && int_pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cause        <= '0;
      badaddr      <= '0;
      epc          <= '0;
      ie_snap      <= 1'b0;
      target       <= '0;
      last_cause   <= '0;
      last_badaddr <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (exc_valid) begin
            cause   <= {1'b0, exc_code};
            badaddr <= exc_badaddr;
            epc     <= exc_pc;
            ie_snap <= ie_in;
          end else if (take_int) begin
            cause   <= {1'b1, int_code};
            badaddr <= '0;
            epc     <= commit_next_pc;
            ie_snap <= ie_in;
          end
        end
        ENTER: begin
          last_cause   <= cause;
          last_badaddr <= badaddr;
          target       <= trap_vector(mtvec_in, cause, RESET_VECTOR);
        end
        RETURN:  target <= mepc_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next              = state;
    exception_context       = '0;
    exception_context_write = 1'b0;
    mepc_out                = '0;
    mepc_write              = 1'b0;
    stall_out               = 1'b0;
    flush_out               = 1'b0;
    redirect_valid          = 1'b0;
    redirect_pc             = '0;
    case (state)
      IDLE: begin
        if (exc_valid || take_int) state_next = ENTER;
        else if (mret_valid)       state_next = RETURN;
      end
      ENTER: begin
        exception_context_write                    = 1'b1;
        exception_context[CTX_MBADADDR_LSB +: 32]  = badaddr;
        exception_context[CTX_MCAUSE_LSB +: 6]     = cause;
        exception_context[CTX_IE1]                 = ie_snap;
        exception_context[CTX_IE]                  = 1'b0;
        mepc_write = 1'b1;
        mepc_out   = epc;
        stall_out  = 1'b1;
        flush_out  = 1'b1;
        state_next = REDIRECT;
      end
      RETURN: begin
        exception_context_write                    = 1'b1;
        exception_context[CTX_MBADADDR_LSB +: 32]  = last_badaddr;
        exception_context[CTX_MCAUSE_LSB +: 6]     = last_cause;
        exception_context[CTX_IE1]                 = 1'b1;
        exception_context[CTX_IE]                  = ie1_in;
        stall_out  = 1'b1;
        flush_out  = 1'b1;
        state_next = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target;
        stall_out      = 1'b1;
        if (redirect_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_trap_controller.sv
// tb_riscv_trap_controller: directed and random trap/MRET transactions against a reference model.
// Rev 1.0
`default_nettype none

module tb_riscv_trap_controller;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0800;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic [31:0] exc_badaddr = '0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_next_pc = '0;
  logic        mret_valid = 1'b0;
  logic        software_interrupt_in = 1'b0;
  logic        timer_interrupt_in = 1'b0;
  logic [7:0]  irq = '0;
  logic [31:0] mie_in = '0;
  logic [31:0] mtvec_in = '0;
  logic [31:0] mepc_in = '0;
  logic        ie_in = 1'b0;
  logic        ie1_in = 1'b0;
  logic        redirect_ready = 1'b0;
  logic [39:0] exception_context;
  logic        exception_context_write;
  logic [31:0] mepc_out;
  logic        mepc_write;
  logic        stall_out;
  logic        flush_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0]  m_last_cause = '0;
  logic [31:0] m_last_bad = '0;
  logic [39:0] obs_ctx;
  logic [31:0] obs_pc;

  riscv_trap_controller #(
    .RESET_VECTOR      (RESET_VECTOR),
    .EXT_IRQ_CODE_BASE (16)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .exc_valid               (exc_valid),
    .exc_code                (exc_code),
    .exc_pc                  (exc_pc),
    .exc_badaddr             (exc_badaddr),
    .commit_valid            (commit_valid),
    .commit_next_pc          (commit_next_pc),
    .mret_valid              (mret_valid),
    .software_interrupt_in   (software_interrupt_in),
    .timer_interrupt_in      (timer_interrupt_in),
    .irq                     (irq),
    .mie_in                  (mie_in),
    .mtvec_in                (mtvec_in),
    .mepc_in                 (mepc_in),
    .ie_in                   (ie_in),
    .ie1_in                  (ie1_in),
    .exception_context       (exception_context),
    .exception_context_write (exception_context_write),
    .mepc_out                (mepc_out),
    .mepc_write              (mepc_write),
    .stall_out               (stall_out),
    .flush_out               (flush_out),
    .redirect_valid          (redirect_valid),
    .redirect_pc             (redirect_pc),
    .redirect_ready          (redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // kind: 0 nothing taken, 1 trap entry, 2 MRET
  function automatic void model(output int kind, output logic [5:0] cause,
                                output logic [31:0] bad, output logic [31:0] epc,
                                output logic [31:0] tgt);
    int c;
    kind = 0; cause = '0; bad = '0; epc = '0; tgt = '0; c = -1;
    if (exc_valid) begin
      kind = 1; cause = {1'b0, exc_code}; bad = exc_badaddr; epc = exc_pc;
    end else if (mret_valid) begin
      kind = 2; tgt = mepc_in;
    end else if (commit_valid && ie_in) begin
      if (software_interrupt_in && mie_in[3]) c = 3;
      else if (timer_interrupt_in && mie_in[7]) c = 7;
      else for (int n = 0; n < 8; n++) if (c < 0 && irq[n] && mie_in[16+n]) c = (16 + n) % 32;
      if (c >= 0) begin
        kind = 1; cause = 6'(32 + c); epc = commit_next_pc;
      end
    end
    if (kind == 1) begin
      if (mtvec_in == 32'd0) tgt = RESET_VECTOR;
      else if (mtvec_in[1:0] == 2'd1 && cause[5]) tgt = (mtvec_in & 32'hFFFF_FFFC) + 32'(cause[4:0]) * 32'd4;
      else tgt = mtvec_in & 32'hFFFF_FFFC;
    end
  endfunction

  // Called at a negedge with the event inputs already applied.
  task automatic run_txn(input int hold, input bit poke);
    int          kind;
    logic [5:0]  cause;
    logic [31:0] bad, epc, tgt;
    logic [39:0] exp_ctx;
    model(kind, cause, bad, epc, tgt);
    exp_ctx = (kind == 1) ? {bad, cause, ie_in, 1'b0} : {m_last_bad, m_last_cause, 1'b1, ie1_in};
    obs_ctx = '0;
    obs_pc  = '0;
    @(posedge clk); #1;
    exc_valid = 1'b0; mret_valid = 1'b0; commit_valid = 1'b0;
    @(negedge clk);
    if (kind == 0) begin
      check("idle_stall", 64'(stall_out), 64'd0);
      check("idle_ctxw", 64'(exception_context_write), 64'd0);
      return;
    end
    obs_ctx = exception_context;
    check("ctx_write", 64'(exception_context_write), 64'd1);
    check("ctx", 64'(exception_context), 64'(exp_ctx));
    check("mepc_write", 64'(mepc_write), 64'(kind == 1));
    if (kind == 1) check("mepc_out", 64'(mepc_out), 64'(epc));
    check("stall_first", 64'(stall_out), 64'd1);
    check("flush", 64'(flush_out), 64'd1);
    check("rv_early", 64'(redirect_valid), 64'd0);
    if (kind == 1) begin
      m_last_cause = cause;
      m_last_bad   = bad;
    end
    @(posedge clk);
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      if (i == 0) obs_pc = redirect_pc;
      check("rv", 64'(redirect_valid), 64'd1);
      check("rstall", 64'(stall_out), 64'd1);
      check("rpc", 64'(redirect_pc), 64'(tgt));
      check("r_ctxw", 64'(exception_context_write), 64'd0);
      check("r_mepcw", 64'(mepc_write), 64'd0);
      check("r_flush", 64'(flush_out), 64'd0);
      redirect_ready = (i == hold);
      if (poke && i < hold) begin
        exc_valid = 1'b1; exc_code = 5'($urandom); exc_pc = $urandom; exc_badaddr = $urandom;
      end
      @(posedge clk); #1;
      exc_valid = 1'b0; redirect_ready = 1'b0;
    end
    @(negedge clk);
    check("done_rv", 64'(redirect_valid), 64'd0);
    check("done_stall", 64'(stall_out), 64'd0);
    check("done_ctxw", 64'(exception_context_write), 64'd0);
  endtask

  task automatic set_quiet();
    exc_valid = 0; mret_valid = 0; commit_valid = 0;
    software_interrupt_in = 0; timer_interrupt_in = 0; irq = '0; mie_in = '0;
  endtask

  initial begin
    #12;
    check("rst_ctx", 64'(exception_context), 64'd0);
    check("rst_stall", 64'(stall_out), 64'd0);
    check("rst_rv", 64'(redirect_valid), 64'd0);
    check("rst_ctxw", 64'(exception_context_write), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);

    // Exception, direct mode
    exc_valid = 1; exc_code = 5'd2; exc_pc = 32'h100; exc_badaddr = 32'hDEAD;
    mtvec_in = 32'h200; ie_in = 1; ie1_in = 0;
    run_txn(3, 0);
    check("dir_exc_ctx", 64'(obs_ctx), 64'({32'h0000_DEAD, 6'h02, 1'b1, 1'b0}));
    check("dir_exc_pc", 64'(obs_pc), 64'h200);

    // Timer interrupt, vectored mode
    set_quiet();
    mtvec_in = 32'h201; mie_in[7] = 1; timer_interrupt_in = 1; commit_valid = 1;
    commit_next_pc = 32'h44;
    run_txn(0, 0);
    check("dir_tmr_cause", 64'(obs_ctx[7:2]), 64'h27);
    check("dir_tmr_pc", 64'(obs_pc), 64'h21C);

    // MRET after the timer trap
    set_quiet();
    ie1_in = 1; mepc_in = 32'h44; mret_valid = 1;
    run_txn(1, 0);
    check("dir_mret_ctx", 64'(obs_ctx), 64'({32'h0, 6'h27, 1'b1, 1'b1}));
    check("dir_mret_pc", 64'(obs_pc), 64'h44);

    // Priority among sw, timer and irq[2]
    set_quiet();
    software_interrupt_in = 1; timer_interrupt_in = 1; irq = 8'h04;
    mie_in = 32'h0004_0088; commit_valid = 1; mtvec_in = 32'h300;
    run_txn(0, 0);
    check("prio_sw", 64'(obs_ctx[7:2]), 64'h23);
    mie_in[3] = 0; commit_valid = 1;
    run_txn(0, 0);
    check("prio_tmr", 64'(obs_ctx[7:2]), 64'h27);
    ie_in = 0; commit_valid = 1;
    run_txn(0, 0);
    check("prio_noie_ctx", 64'(obs_ctx), 64'd0);
    ie_in = 1;

    // Exception and MRET together, backpressure with ignored events
    set_quiet();
    exc_valid = 1; mret_valid = 1; exc_code = 5'd5; exc_pc = 32'h500; exc_badaddr = 32'h1234;
    mtvec_in = 32'd0;
    run_txn(5, 1);
    check("sim_cause", 64'(obs_ctx[7:2]), 64'h05);
    check("sim_pc", 64'(obs_pc), 64'(RESET_VECTOR));

    // Reset while in ENTER
    set_quiet();
    exc_valid = 1; exc_code = 5'd7; exc_pc = 32'h700; exc_badaddr = 32'h99;
    @(posedge clk); #1; exc_valid = 0;
    @(negedge clk);
    check("pre_rst_ctxw", 64'(exception_context_write), 64'd1);
    reset_n = 0; #1;
    check("mid_rst_ctxw", 64'(exception_context_write), 64'd0);
    check("mid_rst_mepcw", 64'(mepc_write), 64'd0);
    check("mid_rst_ctx", 64'(exception_context), 64'd0);
    check("mid_rst_stall", 64'(stall_out), 64'd0);
    check("mid_rst_flush", 64'(flush_out), 64'd0);
    check("mid_rst_rv", 64'(redirect_valid), 64'd0);
    m_last_cause = '0; m_last_bad = '0;
    @(negedge clk); reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_ctxw", 64'(exception_context_write), 64'd0);
      check("post_rst_mepcw", 64'(mepc_write), 64'd0);
    end

    // Random transactions
    for (int t = 0; t < 300; t++) begin
      exc_valid = ($urandom_range(3) == 0);
      mret_valid = ($urandom_range(3) == 0);
      commit_valid = ($urandom_range(9) < 7);
      exc_code = 5'($urandom); exc_pc = $urandom; exc_badaddr = $urandom;
      commit_next_pc = $urandom;
      software_interrupt_in = ($urandom_range(3) == 0);
      timer_interrupt_in = ($urandom_range(3) == 0);
      irq = 8'($urandom & $urandom);
      mie_in = $urandom;
      mtvec_in = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
      ie_in = ($urandom_range(4) != 0);
      ie1_in = 1'($urandom_range(1));
      mepc_in = $urandom;
      run_txn($urandom_range(3), 1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
